serial_adder_unit: RTL and testbench
====================================

Name: serial_adder_unit

Overview:
Multi-cycle, bit-serial add/subtract unit built around one full-adder cell and a registered carry. It consumes one bit pair per clock, LSB first, and produces a WIDTH-bit sum plus carry and overflow flags. It sits in the ALU datapath as the area-optimised alternative to the parallel ripple adder. Operation is controlled by a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2).

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst  input  1  synchronous, active-high reset.
i_start  input  1  request a new operation; sampled only in IDLE.
i_sub  input  1  0 = add, 1 = subtract (i_a - i_b); latched with i_start.
i_a  input  WIDTH  operand A; latched with i_start.
i_b  input  WIDTH  operand B; latched with i_start.
i_cin  input  1  carry-in for add; ignored when i_sub=1.
o_busy  output  1  high while in RUN.
o_done  output  1  one-cycle pulse when results become valid.
o_result  output  WIDTH  sum/difference; holds until the next completion.
o_cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
o_overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset is synchronous, active-high, and has priority over all other inputs. On reset: state=IDLE, o_busy=0, o_done=0, o_result=0, o_cout=0, o_overflow=0, and all internal shift/carry/counter registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, i_start=1:
  - Latch A into shift register SA.
  - Latch B into SB; B is bitwise-inverted when i_sub=1.
  - Carry register C = i_sub ? 1 : i_cin.
  - Bit counter = 0; next state RUN.
- IDLE, i_start=0: remain in IDLE.
- RUN, each cycle:
  - sum = SA[0]^SB[0]^C; C <= majority(SA[0],SB[0],C).
  - SA and SB shift right by 1.
  - Result shift register shifts right, inserting sum at bit WIDTH-1.
  - Counter increments.
  - When counter == WIDTH-1, capture C (the carry into the MSB) as c_msb_in.
- RUN exit: at the end of the cycle with counter == WIDTH-1, load o_result with the final shift value (including the current sum bit). Load o_cout with the new carry and o_overflow with c_msb_in XOR the new carry. Next state DONE.
- DONE: o_done=1 for exactly one cycle, o_busy=0; next state IDLE unconditionally.
- Latency: i_start sampled at edge 0; RUN occupies cycles 1..WIDTH; o_done is high in cycle WIDTH+1; results are valid from that cycle on.
- i_start while in RUN or DONE is ignored; it is not queued.
- Operand inputs are don't-care except at the accepting edge.
- o_result, o_cout and o_overflow change only on the RUN->DONE transition or on reset, never mid-operation.
- Reset during RUN aborts the operation: all outputs read 0 the next cycle; the partial result is discarded.
- i_start and i_rst in the same cycle: reset wins; the block is in IDLE with no operation pending.
- Arithmetic is modulo 2^WIDTH; the carry/borrow is reported only via o_cout.

Test Plan:
1. Assert i_rst for 2 cycles with random inputs -> all outputs 0, o_busy=0; i_start during reset is not accepted.
2. Add 0x35+0x4A, i_cin=0 (WIDTH=8) -> o_busy high for 8 cycles, o_done pulses in cycle 9 after start; o_result=0x7F, o_cout=0, o_overflow=0.
3. Add 0xFF+0x01, i_cin=0 -> o_result=0x00, o_cout=1, o_overflow=0. Add 0x7F+0x00, i_cin=1 -> o_result=0x80, o_cout=0, o_overflow=1.
4. Sub 0x10-0x20 -> o_result=0xF0, o_cout=0, o_overflow=0. Sub 0x80-0x01 -> o_result=0x7F, o_cout=1, o_overflow=1.
5. Start 0x01+0x01; pulse i_start with 0xAA+0x55 at RUN cycle 3 -> second request ignored; o_result=0x02 at o_done; the previous o_result holds throughout RUN.
6. Start 0x35+0x4A; assert i_rst at RUN cycle 4 -> next cycle IDLE, all outputs 0, no o_done pulse. A fresh start then completes normally with 0x7F.

Source files
------------

// File: rtl/serial_adder_unit.sv
// serial_adder_unit: bit-serial add/subtract built around one full-adder cell.
// Operands are consumed LSB first, one bit pair per clock. The result, carry
// and overflow registers update only on completion or on reset.
module serial_adder_unit #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_BIT = CW'(WIDTH - 2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic             c_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             c_msb_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0] b_load;
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] acc_next;

  // Subtraction is A + ~B + 1, so B is inverted bit by bit when loading.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_binv
      assign b_load[gi] = i_b[gi] ^ i_sub;
    end
  endgenerate

  // The single full-adder cell and the next value of the result shifter.
  always_comb begin
    sum_bit    = sa_reg[0] ^ sb_reg[0] ^ c_reg;
    carry_next = (sa_reg[0] & sb_reg[0]) | (sa_reg[0] & c_reg) | (sb_reg[0] & c_reg);
    acc_next   = {sum_bit, acc_reg[WIDTH-1:1]};
  end

  // Control FSM and serial datapath; reset has priority over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= ST_IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      c_reg      <= 1'b0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      c_msb_reg  <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            sa_reg    <= i_a;
            sb_reg    <= b_load;
            c_reg     <= i_sub ? 1'b1 : i_cin;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          c_reg   <= carry_next;
          sa_reg  <= sa_reg >> 1;
          sb_reg  <= sb_reg >> 1;
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + CW'(1);
          // The carry produced by bit WIDTH-2 is the carry into the MSB.
          if (cnt_reg == PENULT_BIT) begin
            c_msb_reg <= carry_next;
          end
          if (cnt_reg == LAST_BIT) begin
            result_reg <= acc_next;
            cout_reg   <= carry_next;
            ovf_reg    <= c_msb_reg ^ carry_next;
            state_reg  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = (state_reg == ST_RUN);
  assign o_done     = (state_reg == ST_DONE);
  assign o_result   = result_reg;
  assign o_cout     = cout_reg;
  assign o_overflow = ovf_reg;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Testbench for serial_adder_unit: directed table, corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_serial_adder_unit;

  localparam int W = 8;

  logic         i_clk;
  logic         i_rst;
  logic         i_start;
  logic         i_sub;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_cin;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_result;
  logic         o_cout;
  logic         o_overflow;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Last completed result, which must hold through any later RUN.
  logic [W-1:0] prev_res;
  logic         prev_cout;
  logic         prev_ovf;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl[6];

  serial_adder_unit #(.WIDTH(W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_sub      (i_sub),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_cin      (i_cin),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_cout     (o_cout),
    .o_overflow (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference: plain modular arithmetic with signed-overflow rule.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, output logic [W-1:0] res, output logic cout,
                       output logic ovf);
    int unsigned bb, full, ci;
    bb   = sub ? ((~int'(b)) & ((1 << W) - 1)) : int'(b);
    ci   = sub ? 1 : int'(cin);
    full = int'(a) + bb + ci;
    res  = full[W-1:0];
    cout = full[W];
    ovf  = (a[W-1] == bb[W-1]) && (res[W-1] != a[W-1]);
  endtask

  // One operation: start at edge 0, watch RUN cycles, check DONE.
  // pulse_at: RUN cycle in which a stray i_start is driven (0 = none).
  // rst_at:   RUN cycle in which reset is asserted (0 = none).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, input int pulse_at, input int rst_at,
                       input string nm);
    logic [W-1:0] er;
    logic         ec, eo;
    model(a, b, sub, cin, er, ec, eo);
    @(negedge i_clk);
    i_a = a; i_b = b; i_sub = sub; i_cin = cin; i_start = 1'b1;
    for (int k = 1; k <= W; k++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      chk({nm, " busy"}, o_busy, 1'b1);
      chk({nm, " nodone"}, o_done, 1'b0);
      chk({nm, " hold"}, {o_cout, o_overflow, o_result}, {prev_cout, prev_ovf, prev_res});
      if (k == pulse_at) begin
        i_a = 8'hAA; i_b = 8'h55; i_sub = 1'b0; i_cin = 1'b0; i_start = 1'b1;
      end
      if (k == rst_at) begin
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk({nm, " abort busy"}, o_busy, 1'b0);
        chk({nm, " abort done"}, o_done, 1'b0);
        chk({nm, " abort outs"}, {o_cout, o_overflow, o_result}, '0);
        for (int j = 0; j < W + 2; j++) begin
          @(negedge i_clk);
          chk({nm, " abort quiet"}, {o_busy, o_done}, 2'b00);
        end
        prev_res = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        $display("op %s: %0h %s %0h aborted by reset", nm, a, sub ? "-" : "+", b);
        return;
      end
    end
    @(negedge i_clk);
    i_start = 1'b0;
    chk({nm, " done"}, o_done, 1'b1);
    chk({nm, " done busy"}, o_busy, 1'b0);
    chk({nm, " result"}, o_result, er);
    chk({nm, " cout"}, o_cout, ec);
    chk({nm, " ovf"}, o_overflow, eo);
    prev_res = er; prev_cout = ec; prev_ovf = eo;
    @(negedge i_clk);
    chk({nm, " idle"}, {o_busy, o_done}, 2'b00);
    chk({nm, " held"}, {o_cout, o_overflow, o_result}, {ec, eo, er});
    $display("op %s: %0h %s %0h cin=%0d -> res=%0h cout=%0d ovf=%0d",
             nm, a, sub ? "-" : "+", b, cin, o_result, o_cout, o_overflow);
  endtask

  initial begin
    logic [W-1:0] er;
    logic         ec, eo;

    tbl[0] = '{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};

    // Reset with random inputs and i_start held high.
    i_rst = 1'b1; i_start = 1'b1;
    i_a = W'($urandom); i_b = W'($urandom); i_sub = 1'($urandom); i_cin = 1'($urandom);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("reset outs", {o_busy, o_done, o_cout, o_overflow, o_result}, '0);
    i_rst = 1'b0; i_start = 1'b0;
    @(negedge i_clk);
    chk("reset no start", {o_busy, o_done}, 2'b00);
    $display("reset: busy=%0d done=%0d res=%0h", o_busy, o_done, o_result);
    prev_res = '0; prev_cout = 1'b0; prev_ovf = 1'b0;

    // Directed table: spec values checked directly, then through the model.
    for (int i = 0; i < 6; i++) begin
      model(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, er, ec, eo);
      chk($sformatf("model vec%0d", i), {er, ec, eo}, {tbl[i].res, tbl[i].cout, tbl[i].ovf});
      do_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, 0, 0, $sformatf("vec%0d", i));
    end

    // Stray start during RUN is ignored and not queued.
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 3, 0, "ignore");
    chk("ignore result", o_result, 8'h02);
    @(negedge i_clk);
    chk("ignore no queue", {o_busy, o_done}, 2'b00);

    // Reset in RUN cycle 4 aborts; fresh start then completes normally.
    do_op(8'h35, 8'h4A, 1'b0, 1'b0, 0, 4, "abort");
    do_op(8'h35, 8'h4A, 1'b0, 1'b0, 0, 0, "restart");
    chk("restart result", o_result, 8'h7F);

    // Randomized operations with occasional stray starts.
    for (int n = 0; n < 40; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0, 0,
            $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
